// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and default 25 MHz timing for the key conditioner.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } key_state_t;

    localparam int unsigned DEFAULT_NUM_KEYS        = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;    // 10 ms at 25 MHz
    localparam int unsigned DEFAULT_STEP_KEY        = 1;
    localparam int unsigned DEFAULT_REPEAT_DELAY    = 12500000;  // 500 ms at 25 MHz
    localparam int unsigned DEFAULT_REPEAT_PERIOD   = 2500000;   // 100 ms at 25 MHz

endpackage

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm: one key channel -- 2-flop synchronizer, debounce FSM with
// a stability counter, registered press/release pulses and the debounced level.
// press_next is the value key_press will take at the next edge, so the top can
// register a step pulse aligned with key_press. level_next exists only when
// KEY_AUTOREPEAT_EN is defined.
module key_debounce_fsm
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
`ifdef KEY_AUTOREPEAT_EN
    output logic level_next,
`endif
    output logic press_next
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_n;
    key_state_t       state_q;
    key_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_d;
    logic             release_d;

    // Bring the asynchronous pin into the clock domain; idle value is released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b1;
            sync_n    <= 1'b1;
        end else begin
            sync_meta <= key_n;
            sync_n    <= sync_meta;
        end
    end

    // State, stability counter and output pulse registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_press   <= press_d;
            key_release <= release_d;
        end
    end

    // Next state: a change is only accepted after the synchronized pin has held
    // its new value long enough; any reversal during the wait is a bounce.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sync_n) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (sync_n) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!sync_n) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_level  = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign press_next = press_d;

`ifdef KEY_AUTOREPEAT_EN
    assign level_next = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
`endif

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounces NUM_KEYS active-low push-buttons into active-high
// levels and one-cycle press/release pulses, and derives a single-step enable
// from STEP_KEY. Define KEY_AUTOREPEAT_EN to make a held STEP_KEY repeat the
// step pulse after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = DEFAULT_NUM_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned STEP_KEY        = DEFAULT_STEP_KEY,
    parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                step_pulse
);

    localparam logic [NUM_KEYS-1:0] STEP_MASK = NUM_KEYS'(1) << STEP_KEY;

    if (DEBOUNCE_CYCLES < 2 || STEP_KEY >= NUM_KEYS ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_conditioner: parameter out of range");
    end

    logic [NUM_KEYS-1:0] press_next;
    logic                step_press_next;

`ifdef KEY_AUTOREPEAT_EN
    logic [NUM_KEYS-1:0] level_next;
`endif

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_fsm #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_fsm (
            .clock      (clock),
            .reset      (reset),
            .key_n      (key_n[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
`ifdef KEY_AUTOREPEAT_EN
            .level_next (level_next[i]),
`endif
            .press_next (press_next[i])
        );
    end

    assign step_press_next = |(press_next & STEP_MASK);

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RPT_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W    = (RPT_SPAN > 1) ? $clog2(RPT_SPAN) : 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic             step_held_now;
    logic             step_held_next;
    logic             rpt_first;
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_last;

    assign step_held_now  = |(key_level & STEP_MASK);
    assign step_held_next = |(level_next & STEP_MASK);
    assign rpt_last       = rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST;

    // Repeat timer runs only while the step key stays held across the edge, so a
    // repeat can never land on the cycle the key is released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rpt_cnt    <= '0;
            rpt_first  <= 1'b1;
            step_pulse <= 1'b0;
        end else if (!(step_held_now && step_held_next)) begin
            rpt_cnt    <= '0;
            rpt_first  <= 1'b1;
            step_pulse <= step_press_next;
        end else if (rpt_cnt == rpt_last) begin
            rpt_cnt    <= '0;
            rpt_first  <= 1'b0;
            step_pulse <= 1'b1;
        end else begin
            rpt_cnt    <= rpt_cnt + RPT_W'(1);
            step_pulse <= 1'b0;
        end
    end
`else
    // Step enable registered alongside key_press so both rise in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= step_press_next;
        end
    end
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: randomized and directed checks of key_conditioner against
// a run-length reference model (a change is accepted once the synchronized pin
// has disagreed with the accepted level for DEBOUNCE_CYCLES+1 consecutive edges).
module tb_key_conditioner;

    localparam int NK = 4;
    localparam int DB = 8;
    localparam int SK = 1;
    localparam int RD = 20;
    localparam int RP = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NK-1:0] key_n = '0;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          step_pulse;

    int errors = 0;
    int checks = 0;

    key_conditioner #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DB),
        .STEP_KEY       (SK),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .step_pulse (step_pulse)
    );

    always #5 clock = ~clock;

    // Reference model state, updated once per rising edge.
    logic [NK-1:0] m_s1 = '1;
    logic [NK-1:0] m_s2 = '1;
    logic [NK-1:0] m_level = '0;
    logic [NK-1:0] m_press = '0;
    logic [NK-1:0] m_release = '0;
    logic          m_step = 1'b0;
    int            m_run [NK];
    int            m_age = 0;

    // Model: pin delayed two edges, accepted level flips after DB+1 disagreeing samples.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_s1 = '1; m_s2 = '1; m_level = '0; m_press = '0; m_release = '0;
            m_step = 1'b0; m_age = 0;
            for (int k = 0; k < NK; k++) m_run[k] = 0;
        end else begin
            m_press = '0;
            m_release = '0;
            for (int k = 0; k < NK; k++) begin
                if ((!m_s2[k]) != m_level[k]) m_run[k] = m_run[k] + 1;
                else m_run[k] = 0;
                if (m_run[k] == DB + 1) begin
                    m_level[k] = !m_level[k];
                    if (m_level[k]) m_press[k] = 1'b1;
                    else m_release[k] = 1'b1;
                    m_run[k] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = key_n;
            if (m_press[SK]) m_age = 0;
            else if (m_level[SK]) m_age = m_age + 1;
            else m_age = 0;
            m_step = m_press[SK];
`ifdef KEY_AUTOREPEAT_EN
            if (m_level[SK] && !m_press[SK] && m_age >= RD && ((m_age - RD) % RP) == 0)
                m_step = 1'b1;
`endif
        end
    end

    function automatic logic [12:0] dut_out();
        return {key_level, key_press, key_release, step_pulse};
    endfunction

    function automatic logic [12:0] model_out();
        return {m_level, m_press, m_release, m_step};
    endfunction

    // Reset hold with keys down, then release: all four keys debounce afresh.
    task automatic test_reset();
        int press_at = -1;
        int press_cnt = 0;
        int rel_at = -1;
        reset = 1'b0;
        key_n = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (dut_out() !== 13'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold got=%b want=%b", dut_out(), 13'd0);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("[TB] FAIL reset_model i=%0d got=%b want=%b", i, dut_out(), model_out());
            end
            if (key_press === 4'b1111) begin
                press_cnt++;
                if (press_at < 0) press_at = i;
            end
        end
        checks++;
        if (press_at != 10 || press_cnt != 1) begin
            errors++;
            $display("[TB] FAIL reset_press_latency got at=%0d n=%0d want at=10 n=1", press_at, press_cnt);
        end
        key_n = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("[TB] FAIL release_all_model i=%0d got=%b want=%b", i, dut_out(), model_out());
            end
            if (key_release === 4'b1111 && rel_at < 0) rel_at = i;
        end
        checks++;
        if (rel_at != 10) begin
            errors++;
            $display("[TB] FAIL release_all_latency got=%0d want=10", rel_at);
        end
    endtask

    // Key 0: low 5, high 3, then steady low; only the final run is accepted.
    task automatic test_bounce();
        int press_at = -1;
        int press_cnt = 0;
        int early_level = 0;
        for (int i = 0; i < 46; i++) begin
            key_n = 4'b1111;
            if (i < 5 || (i >= 8 && i < 28)) key_n[0] = 1'b0;
            @(negedge clock);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("[TB] FAIL bounce_model i=%0d got=%b want=%b", i, dut_out(), model_out());
            end
            if (key_press[0] === 1'b1) begin
                press_cnt++;
                if (press_at < 0) press_at = i;
            end
            if (i < 18 && key_level[0] !== 1'b0) early_level++;
        end
        checks++;
        if (press_at != 18 || press_cnt != 1 || early_level != 0) begin
            errors++;
            $display("[TB] FAIL bounce_press got at=%0d n=%0d early=%0d want at=18 n=1 early=0",
                     press_at, press_cnt, early_level);
        end
    endtask

    // Key 2: held 30 cycles then released.
    task automatic test_press_release();
        int press_at = -1;
        int rel_at = -1;
        logic mid_level = 1'b0;
        for (int i = 0; i < 50; i++) begin
            key_n = (i < 30) ? 4'b1011 : 4'b1111;
            @(negedge clock);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("[TB] FAIL press_release_model i=%0d got=%b want=%b", i, dut_out(), model_out());
            end
            if (key_press[2] === 1'b1 && press_at < 0) press_at = i;
            if (key_release[2] === 1'b1 && rel_at < 0) rel_at = i;
            if (i == 25) mid_level = key_level[2];
        end
        checks++;
        if (press_at != 10 || rel_at != 40 || mid_level !== 1'b1 || key_level[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL press_release_timing got p=%0d r=%0d mid=%b end=%b want p=10 r=40 mid=1 end=0",
                     press_at, rel_at, mid_level, key_level[2]);
        end
    endtask

    // Step key raises step_pulse with key_press; another key never does.
    task automatic test_step();
        int steps = 0;
        int misaligned = 0;
        int other_steps = 0;
        for (int i = 0; i < 30; i++) begin
            key_n = (i < 15) ? 4'b1101 : 4'b1111;
            @(negedge clock);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("[TB] FAIL step_model i=%0d got=%b want=%b", i, dut_out(), model_out());
            end
            if (step_pulse === 1'b1) steps++;
            if (step_pulse !== key_press[1]) misaligned++;
        end
        checks++;
        if (steps != 1 || misaligned != 0) begin
            errors++;
            $display("[TB] FAIL step_key1 got steps=%0d misaligned=%0d want steps=1 misaligned=0", steps, misaligned);
        end
        for (int i = 0; i < 30; i++) begin
            key_n = (i < 15) ? 4'b0111 : 4'b1111;
            @(negedge clock);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("[TB] FAIL step_other_model i=%0d got=%b want=%b", i, dut_out(), model_out());
            end
            if (step_pulse !== 1'b0) other_steps++;
        end
        checks++;
        if (other_steps != 0) begin
            errors++;
            $display("[TB] FAIL step_key3 got steps=%0d want 0", other_steps);
        end
    endtask

    // Reset four cycles into the press wait, key still held afterwards.
    task automatic test_mid_reset();
        int press_at = -1;
        int press_cnt = 0;
        key_n = 4'b1110;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("[TB] FAIL mid_reset_pre i=%0d got=%b want=%b", i, dut_out(), model_out());
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (dut_out() !== 13'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_async got=%b want=%b", dut_out(), 13'd0);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("[TB] FAIL mid_reset_model i=%0d got=%b want=%b", i, dut_out(), model_out());
            end
            if (key_press[0] === 1'b1) begin
                press_cnt++;
                if (press_at < 0) press_at = i;
            end
        end
        checks++;
        if (press_at != 10 || press_cnt != 1) begin
            errors++;
            $display("[TB] FAIL mid_reset_latency got at=%0d n=%0d want at=10 n=1", press_at, press_cnt);
        end
        key_n = 4'b1111;
        repeat (14) @(negedge clock);
    endtask

    // Random bouncy runs on all keys, compared cycle by cycle with the model.
    task automatic test_random();
        int left [NK];
        int both = 0;
        for (int k = 0; k < NK; k++) left[k] = 0;
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < NK; k++) begin
                if (left[k] == 0) begin
                    key_n[k] = ~key_n[k];
                    left[k] = $urandom_range(14, 1);
                end
                left[k]--;
            end
            @(negedge clock);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("[TB] FAIL random_model i=%0d got=%b want=%b", i, dut_out(), model_out());
            end
            if ((key_press & key_release) !== 4'b0000) both++;
        end
        checks++;
        if (both != 0) begin
            errors++;
            $display("[TB] FAIL random_press_and_release got=%0d want=0", both);
        end
        key_n = 4'b1111;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("[TB] FAIL random_settle i=%0d got=%b want=%b", i, dut_out(), model_out());
            end
        end
    endtask

`ifdef KEY_AUTOREPEAT_EN
    // Step key held 50 cycles: press at 10, repeats at 30, 35, ... 55.
    task automatic test_autorepeat();
        int wrong = 0;
        int presses = 0;
        logic want;
        for (int i = 0; i < 70; i++) begin
            key_n = (i < 50) ? 4'b1101 : 4'b1111;
            @(negedge clock);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("[TB] FAIL repeat_model i=%0d got=%b want=%b", i, dut_out(), model_out());
            end
            want = (i == 10) || (i >= 30 && i < 60 && ((i - 30) % 5) == 0);
            if (step_pulse !== want) wrong++;
            if (key_press[1] === 1'b1) presses++;
        end
        checks++;
        if (wrong != 0 || presses != 1) begin
            errors++;
            $display("[TB] FAIL repeat_schedule got wrong=%0d presses=%0d want wrong=0 presses=1", wrong, presses);
        end
    endtask
`endif

    initial begin
        @(negedge clock);
        test_reset();
        test_bounce();
        test_press_release();
        test_step();
        test_mid_reset();
        test_random();
`ifdef KEY_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
